// File: rtl/riscv_pkg.sv
// Shared types and constants for the EX-stage sequencer.
// Holds the branch-condition helper used by the sequencer.
package riscv_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        BR_BEQ = 2'd0,
        BR_BNE = 2'd1,
        BR_BLT = 2'd2,
        BR_BGE = 2'd3
    } br_type_t;

    typedef enum logic {
        EX_RUN   = 1'b0,
        EX_FLUSH = 1'b1
    } ex_state_t;

    function automatic logic br_taken(input br_type_t br_type, input logic zero, input logic negative);
        logic taken;
        case (br_type)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            BR_BLT:  taken = negative;
            BR_BGE:  taken = !negative;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_seq_if.sv
// ID/EX -> EX/MEM handshake bundle, including the fetch redirect and flush.
// Signal names are from the sequencer's point of view.
interface ex_seq_if #(parameter int XLEN = riscv_pkg::XLEN_DEF);

    logic                            i_valid;
    logic                            o_ready;
    logic                            i_branch;
    logic [1:0]                      i_br_type;
    logic                            i_zero;
    logic                            i_negative;
    logic [XLEN-1:0]                 i_pc_branch;
    logic [XLEN-1:0]                 i_alu_result;
    logic [riscv_pkg::REG_ADDR_W-1:0] i_rd;
    logic                            i_reg_write;
    logic                            o_valid;
    logic                            i_ready;
    logic [XLEN-1:0]                 o_alu_result;
    logic [riscv_pkg::REG_ADDR_W-1:0] o_rd;
    logic                            o_reg_write;
    logic                            o_redirect;
    logic [XLEN-1:0]                 o_redirect_pc;
    logic                            o_flush;

    modport slave (
        input  i_valid, i_branch, i_br_type, i_zero, i_negative, i_pc_branch,
               i_alu_result, i_rd, i_reg_write, i_ready,
        output o_ready, o_valid, o_alu_result, o_rd, o_reg_write,
               o_redirect, o_redirect_pc, o_flush
    );

    modport master (
        output i_valid, i_branch, i_br_type, i_zero, i_negative, i_pc_branch,
               i_alu_result, i_rd, i_reg_write, i_ready,
        input  o_ready, o_valid, o_alu_result, o_rd, o_reg_write,
               o_redirect, o_redirect_pc, o_flush
    );

endinterface

// File: rtl/ex_seq_ctrl_out_buf.sv
// One-entry EX/MEM output register holding {alu_result, rd, reg_write}.
// A load always wins over a drain, which gives full throughput.
module ex_out_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_ready,
    input  logic [XLEN-1:0]       i_alu_result,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_reg_write,
    output logic                  o_valid,
    output logic [XLEN-1:0]       o_alu_result,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_reg_write
);

    logic                  valid_r;
    logic [XLEN-1:0]       result_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic                  reg_write_r;

    // Entry register: payload only changes on a load, so it is stable while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_r     <= 1'b0;
            result_r    <= '0;
            rd_r        <= '0;
            reg_write_r <= 1'b0;
        end else if (i_load) begin
            valid_r     <= 1'b1;
            result_r    <= i_alu_result;
            rd_r        <= i_rd;
            reg_write_r <= i_reg_write;
        end else if (i_ready) begin
            valid_r     <= 1'b0;
        end else begin
            valid_r     <= valid_r;
        end
    end

    assign o_valid      = valid_r;
    assign o_alu_result = result_r;
    assign o_rd         = rd_r;
    assign o_reg_write  = reg_write_r;

endmodule

// File: rtl/ex_seq_ctrl.sv
// EX-stage sequencer: resolves conditional branches, pulses a fetch redirect,
// squashes wrong-path instructions for FLUSH_CYCLES cycles and buffers results.
module ex_seq_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    ex_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] FLUSH_LD_C = CNT_W'(FLUSH_CYCLES);

    ex_state_t        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             redirect_r, redirect_nxt_s;
    logic [XLEN-1:0]  redirect_pc_r, redirect_pc_nxt_s;
    logic             out_valid_s;
    logic             ready_s;
    logic             accept_s;
    logic             taken_s;
    logic             load_s;

    assign ready_s  = !out_valid_s || bus.i_ready;
    assign accept_s = bus.i_valid && ready_s;
    assign taken_s  = br_taken(br_type_t'(bus.i_br_type), bus.i_zero, bus.i_negative);

    // Next-state and redirect decode. A taken branch during the redirect cycle
    // is not resolved, so the redirect can never pulse on consecutive cycles.
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        redirect_nxt_s    = 1'b0;
        redirect_pc_nxt_s = redirect_pc_r;
        load_s            = 1'b0;
        case (state_r)
            EX_RUN: begin
                if (accept_s && !bus.i_branch) begin
                    load_s = 1'b1;
                end else if (accept_s && taken_s && !redirect_r) begin
                    redirect_nxt_s    = 1'b1;
                    redirect_pc_nxt_s = bus.i_pc_branch;
                    if (FLUSH_LD_C != 4'd0) begin
                        state_nxt_s = EX_FLUSH;
                        cnt_nxt_s   = FLUSH_LD_C;
                    end else begin
                        state_nxt_s = EX_RUN;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            EX_FLUSH: begin
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = EX_RUN;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = EX_RUN;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Sequencer state, squash counter and redirect registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r       <= EX_RUN;
            cnt_r         <= 4'd0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= '0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            redirect_r    <= redirect_nxt_s;
            redirect_pc_r <= redirect_pc_nxt_s;
        end
    end

    ex_out_buf #(.XLEN(XLEN)) u_out_buf (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (load_s),
        .i_ready      (bus.i_ready),
        .i_alu_result (bus.i_alu_result),
        .i_rd         (bus.i_rd),
        .i_reg_write  (bus.i_reg_write),
        .o_valid      (out_valid_s),
        .o_alu_result (bus.o_alu_result),
        .o_rd         (bus.o_rd),
        .o_reg_write  (bus.o_reg_write)
    );

    assign bus.o_ready       = ready_s;
    assign bus.o_valid       = out_valid_s;
    assign bus.o_redirect    = redirect_r;
    assign bus.o_redirect_pc = redirect_pc_r;
    assign bus.o_flush       = (state_r == EX_FLUSH);

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Bench for ex_seq_ctrl: two instances (FLUSH_CYCLES=2 and 0) share one stimulus
// stream; each is compared with a transaction-level model of the sequencer.
module tb_ex_seq_ctrl;

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic [3:0]  win;
        logic        redir;
        logic [31:0] rpc;
    } mstate_t;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    int      total = 0;
    int      bad = 0;
    mstate_t m0 = '0;
    mstate_t m1 = '0;

    always #5 clk = ~clk;

    ex_seq_if #(.XLEN(32)) b0 ();
    ex_seq_if #(.XLEN(32)) b1 ();

    ex_seq_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave));
    ex_seq_ctrl #(.XLEN(32), .FLUSH_CYCLES(0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave));

    // Model: a squash window counts down remaining discard cycles; otherwise an
    // accepted non-branch fills the entry and an accepted taken branch redirects.
    function automatic mstate_t mnext(input mstate_t s, input int fc);
        mstate_t n;
        logic    taken;
        logic    acc;
        n = s;
        if (!rst_n) return mstate_t'(0);
        n.redir = 1'b0;
        case (b0.i_br_type)
            2'd0:    taken = b0.i_zero;
            2'd1:    taken = !b0.i_zero;
            2'd2:    taken = b0.i_negative;
            default: taken = !b0.i_negative;
        endcase
        acc = b0.i_valid && (!s.v || b0.i_ready);
        if (b0.i_ready) n.v = 1'b0;
        if (s.win > 4'd0) begin
            n.win = s.win - 4'd1;
        end else if (acc && !b0.i_branch) begin
            n.v = 1'b1; n.res = b0.i_alu_result; n.rd = b0.i_rd; n.rw = b0.i_reg_write;
        end else if (acc && taken && !s.redir) begin
            n.redir = 1'b1; n.rpc = b0.i_pc_branch; n.win = 4'(fc);
        end
        return n;
    endfunction

    task automatic drive(input logic v, input logic br, input logic [1:0] bt, input logic z,
                         input logic n, input logic [31:0] pc, input logic [31:0] res,
                         input logic [4:0] rd, input logic rw, input logic rdy);
        b0.i_valid = v;  b0.i_branch = br; b0.i_br_type = bt; b0.i_zero = z; b0.i_negative = n;
        b0.i_pc_branch = pc; b0.i_alu_result = res; b0.i_rd = rd; b0.i_reg_write = rw; b0.i_ready = rdy;
        b1.i_valid = v;  b1.i_branch = br; b1.i_br_type = bt; b1.i_zero = z; b1.i_negative = n;
        b1.i_pc_branch = pc; b1.i_alu_result = res; b1.i_rd = rd; b1.i_reg_write = rw; b1.i_ready = rdy;
        #1;
    endtask

    task automatic tick();
        m0 = mnext(m0, 2);
        m1 = mnext(m1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0005, 5'd3, 1'b1, 1'b1);
        tick();
        tick();
        total++;
        if ({b0.o_valid, b0.o_alu_result, b0.o_rd, b0.o_reg_write} !== 39'd0) begin
            bad++; $display("FAIL reset_buf got=%h want=0", {b0.o_valid, b0.o_alu_result, b0.o_rd, b0.o_reg_write});
        end
        total++;
        if ({b0.o_redirect, b0.o_redirect_pc, b0.o_flush, b0.o_ready} !== 35'd1) begin
            bad++; $display("FAIL reset_ctl got=%h want=1", {b0.o_redirect, b0.o_redirect_pc, b0.o_flush, b0.o_ready});
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (b0.o_valid !== 1'b1 || b0.o_alu_result !== 32'h5 || b0.o_rd !== 5'd3) begin
            bad++; $display("FAIL reset_first_add got=%b/%h/%0d want=1/5/3", b0.o_valid, b0.o_alu_result, b0.o_rd);
        end
    endtask

    task automatic test_backpressure();
        idle();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h1111_0001, 5'd1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h2222_0002 + 32'(i), 5'd2, 1'b0, 1'b0);
            total++;
            if (b0.o_ready !== 1'b0) begin
                bad++; $display("FAIL bp_ready got=%b want=0", b0.o_ready);
            end
            tick();
            total++;
            if (b0.o_valid !== 1'b1 || b0.o_alu_result !== 32'h1111_0001 || b0.o_rd !== 5'd1) begin
                bad++; $display("FAIL bp_stable got=%b/%h/%0d want=1/11110001/1", b0.o_valid, b0.o_alu_result, b0.o_rd);
            end
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h2222_0002, 5'd2, 1'b0, 1'b1);
        tick();
        total++;
        if (b0.o_valid !== 1'b1 || b0.o_alu_result !== 32'h2222_0002) begin
            bad++; $display("FAIL bp_drain_b got=%b/%h want=1/22220002", b0.o_valid, b0.o_alu_result);
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h3333_0003, 5'd3, 1'b1, 1'b1);
        tick();
        total++;
        if (b0.o_valid !== 1'b1 || b0.o_alu_result !== 32'h3333_0003) begin
            bad++; $display("FAIL bp_drain_c got=%b/%h want=1/33330003", b0.o_valid, b0.o_alu_result);
        end
        idle();
        total++;
        if (b0.o_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty got=%b want=0", b0.o_valid);
        end
    endtask

    task automatic test_beq_flush();
        idle();
        drive(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        total++;
        if (b0.o_redirect !== 1'b1 || b0.o_redirect_pc !== 32'h100 || b0.o_flush !== 1'b1) begin
            bad++; $display("FAIL beq_redirect got=%b/%h/%b want=1/100/1", b0.o_redirect, b0.o_redirect_pc, b0.o_flush);
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'hDEAD_0001, 5'd7, 1'b1, 1'b1);
        tick();
        total++;
        if (b0.o_redirect !== 1'b0 || b0.o_flush !== 1'b1 || b0.o_valid !== 1'b0) begin
            bad++; $display("FAIL beq_win2 got=%b/%b/%b want=0/1/0", b0.o_redirect, b0.o_flush, b0.o_valid);
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'hDEAD_0002, 5'd8, 1'b1, 1'b1);
        tick();
        total++;
        if (b0.o_flush !== 1'b0 || b0.o_valid !== 1'b0) begin
            bad++; $display("FAIL beq_win_end got=%b/%b want=0/0", b0.o_flush, b0.o_valid);
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0A0A, 5'd9, 1'b1, 1'b1);
        tick();
        total++;
        if (b0.o_valid !== 1'b1 || b0.o_alu_result !== 32'h0A0A) begin
            bad++; $display("FAIL beq_after got=%b/%h want=1/a0a", b0.o_valid, b0.o_alu_result);
        end
    endtask

    task automatic test_not_taken();
        idle();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd0, 1'b0, 1'b1);
            else        drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 5'd0, 1'b0, 1'b1);
            tick();
            total++;
            if (b0.o_redirect !== 1'b0 || b0.o_flush !== 1'b0 || b0.o_valid !== 1'b0) begin
                bad++; $display("FAIL not_taken_%0d got=%b/%b/%b want=0/0/0", i, b0.o_redirect, b0.o_flush, b0.o_valid);
            end
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0777, 5'd11, 1'b1, 1'b1);
        tick();
        total++;
        if (b0.o_valid !== 1'b1 || b0.o_alu_result !== 32'h777 || b0.o_rd !== 5'd11) begin
            bad++; $display("FAIL not_taken_next got=%b/%h/%0d want=1/777/11", b0.o_valid, b0.o_alu_result, b0.o_rd);
        end
    endtask

    task automatic test_flush0();
        idle();
        drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        total++;
        if (b1.o_redirect !== 1'b1 || b1.o_redirect_pc !== 32'h200 || b1.o_flush !== 1'b0) begin
            bad++; $display("FAIL f0_redirect got=%b/%h/%b want=1/200/0", b1.o_redirect, b1.o_redirect_pc, b1.o_flush);
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0B0B, 5'd12, 1'b1, 1'b1);
        tick();
        total++;
        if (b1.o_redirect !== 1'b0 || b1.o_valid !== 1'b1 || b1.o_alu_result !== 32'hB0B || b1.o_flush !== 1'b0) begin
            bad++; $display("FAIL f0_next got=%b/%b/%h/%b want=0/1/b0b/0", b1.o_redirect, b1.o_valid, b1.o_alu_result, b1.o_flush);
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid_flush();
        idle();
        drive(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0C0C, 5'd13, 1'b1, 1'b1);
        tick();
        total++;
        if (b0.o_flush !== 1'b0 || b0.o_redirect !== 1'b0 || b0.o_valid !== 1'b0 || b0.o_redirect_pc !== 32'h0) begin
            bad++; $display("FAIL rst_flush got=%b/%b/%b/%h want=0/0/0/0", b0.o_flush, b0.o_redirect, b0.o_valid, b0.o_redirect_pc);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0D0D, 5'd14, 1'b1, 1'b1);
        tick();
        total++;
        if (b0.o_valid !== 1'b1 || b0.o_alu_result !== 32'hD0D || b0.o_flush !== 1'b0) begin
            bad++; $display("FAIL rst_flush_after got=%b/%h/%b want=1/d0d/0", b0.o_valid, b0.o_alu_result, b0.o_flush);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            total++;
            if ({b0.o_ready, b0.o_valid, b0.o_alu_result, b0.o_rd, b0.o_reg_write, b0.o_redirect, b0.o_redirect_pc, b0.o_flush} !==
                {(!m0.v || b0.i_ready), m0.v, m0.res, m0.rd, m0.rw, m0.redir, m0.rpc, (m0.win != 4'd0)}) begin
                bad++; $display("FAIL rand_f2 cyc=%0d got=%b/%b/%h/%0d/%b/%b/%h/%b want=%b/%b/%h/%0d/%b/%b/%h/%b", i,
                    b0.o_ready, b0.o_valid, b0.o_alu_result, b0.o_rd, b0.o_reg_write, b0.o_redirect, b0.o_redirect_pc, b0.o_flush,
                    (!m0.v || b0.i_ready), m0.v, m0.res, m0.rd, m0.rw, m0.redir, m0.rpc, (m0.win != 4'd0));
            end
            total++;
            if ({b1.o_ready, b1.o_valid, b1.o_alu_result, b1.o_rd, b1.o_reg_write, b1.o_redirect, b1.o_redirect_pc, b1.o_flush} !==
                {(!m1.v || b1.i_ready), m1.v, m1.res, m1.rd, m1.rw, m1.redir, m1.rpc, 1'b0}) begin
                bad++; $display("FAIL rand_f0 cyc=%0d got=%b/%b/%h/%0d/%b/%b/%h/%b want=%b/%b/%h/%0d/%b/%b/%h/0", i,
                    b1.o_ready, b1.o_valid, b1.o_alu_result, b1.o_rd, b1.o_reg_write, b1.o_redirect, b1.o_redirect_pc, b1.o_flush,
                    (!m1.v || b1.i_ready), m1.v, m1.res, m1.rd, m1.rw, m1.redir, m1.rpc);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_beq_flush();
        test_not_taken();
        test_flush0();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
